// File: rtl/i2c_poll_sequencer.sv
// Periodic poller: reads NUM_REGS registers of one I2C slave as pointer-write/byte-read pairs, retrying NACKs.
// Latency: m_start 2 cycles after trigger/tick, out_valid 1 cycle after the read m_done, frame_done 1 cycle after last out_valid.
// Backpressure: each request waits for m_busy=0 and holds m_start until m_busy=1; watchdog only under POLL_SEQ_TIMEOUT_EN.
module i2c_poll_sequencer #(
    parameter logic [6:0] SLAVE_ADDR     = 7'h48,
    parameter logic [7:0] REG_BASE       = 8'h00,
    parameter int         NUM_REGS       = 4,
    parameter int         POLL_PERIOD    = 5_000_000,
    parameter int         MAX_RETRY      = 3,
    parameter int         TIMEOUT_CYCLES = 200_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       trigger,
    output logic       m_start,
    output logic [6:0] m_addr,
    output logic       m_rw,
    output logic [7:0] m_data_wr,
    input  logic [7:0] m_data_rd,
    input  logic       m_busy,
    input  logic       m_ack_error,
    input  logic       m_done,
    output logic       seq_busy,
    output logic       out_valid,
    output logic [3:0] out_index,
    output logic [7:0] out_data,
    output logic       frame_done,
    output logic       frame_ok,
    output logic       err_nack,
    output logic       err_timeout,
    output logic       overrun
);

    typedef enum logic [2:0] {
        S_IDLE, S_PTR_REQ, S_PTR_WAIT, S_RD_REQ, S_RD_WAIT, S_EMIT, S_FAIL, S_FINISH
    } state_t;

    localparam int             PCW         = $clog2(POLL_PERIOD);
    localparam logic [PCW-1:0] PERIOD_LAST = PCW'(POLL_PERIOD - 1);
    localparam logic [3:0]     IDX_LAST    = 4'(NUM_REGS - 1);
    localparam logic [2:0]     RETRY_MAX   = 3'(MAX_RETRY);

    state_t         state_q, state_d;
    logic [PCW-1:0] period_cnt_q, period_cnt_d;
    logic [3:0]     idx_q, idx_d;
    logic [2:0]     retry_q, retry_d;
    logic           m_start_q, m_start_d;
    logic           m_rw_q, m_rw_d;
    logic [7:0]     m_data_wr_q, m_data_wr_d;
    logic           out_valid_q, out_valid_d;
    logic [3:0]     out_index_q, out_index_d;
    logic [7:0]     out_data_q, out_data_d;
    logic           frame_done_q, frame_done_d;
    logic           frame_ok_q, frame_ok_d;
    logic           err_nack_q, err_nack_d;
    logic           err_timeout_q, err_timeout_d;
    logic           overrun_q, overrun_d;
    logic           fail_tmo_q, fail_tmo_d;
    logic           tick;
    logic           in_req_wait;
    logic           wd_expired;

    assign tick        = (period_cnt_q == '0);
    assign in_req_wait = (state_q == S_PTR_REQ) || (state_q == S_RD_REQ) ||
                         (state_q == S_PTR_WAIT) || (state_q == S_RD_WAIT);

`ifdef POLL_SEQ_TIMEOUT_EN
    localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WCW-1:0] wd_cnt_q, wd_cnt_d;

    // Restarts from zero whenever the state changes, so each REQ/WAIT visit gets its own budget.
    always_comb begin
        wd_cnt_d = '0;
        if (in_req_wait && (state_d == state_q)) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
    end

    assign wd_expired = in_req_wait && (wd_cnt_q == WCW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
`else
    assign wd_expired = 1'b0;
`endif

    always_comb begin
        period_cnt_d = tick ? PERIOD_LAST : period_cnt_q - 1'b1;
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        retry_d       = retry_q;
        m_start_d     = m_start_q;
        m_rw_d        = m_rw_q;
        m_data_wr_d   = m_data_wr_q;
        out_valid_d   = 1'b0;
        out_index_d   = out_index_q;
        out_data_d    = out_data_q;
        frame_done_d  = 1'b0;
        frame_ok_d    = frame_ok_q;
        err_nack_d    = 1'b0;
        err_timeout_d = 1'b0;
        fail_tmo_d    = fail_tmo_q;
        overrun_d     = tick && enable && (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (trigger || (tick && enable)) begin
                    state_d     = S_PTR_REQ;
                    idx_d       = '0;
                    retry_d     = '0;
                    m_rw_d      = 1'b0;
                    m_data_wr_d = REG_BASE;
                end
            end
            S_PTR_REQ, S_RD_REQ: begin
                if (wd_expired) begin
                    m_start_d  = 1'b0;
                    fail_tmo_d = 1'b1;
                    state_d    = S_FAIL;
                end else if (m_start_q && m_busy) begin
                    m_start_d = 1'b0;
                    state_d   = (state_q == S_PTR_REQ) ? S_PTR_WAIT : S_RD_WAIT;
                end else if (!m_busy) begin
                    m_start_d = 1'b1;
                end
            end
            S_PTR_WAIT, S_RD_WAIT: begin
                if (wd_expired) begin
                    fail_tmo_d = 1'b1;
                    state_d    = S_FAIL;
                end else if (m_done) begin
                    if (m_ack_error) begin
                        fail_tmo_d = 1'b0;
                        state_d    = S_FAIL;
                    end else if (state_q == S_PTR_WAIT) begin
                        m_rw_d  = 1'b1;
                        state_d = S_RD_REQ;
                    end else begin
                        out_data_d  = m_data_rd;
                        out_index_d = idx_q;
                        out_valid_d = 1'b1;
                        state_d     = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                retry_d = '0;
                if (idx_q == IDX_LAST) begin
                    frame_ok_d   = 1'b1;
                    frame_done_d = 1'b1;
                    state_d      = S_FINISH;
                end else begin
                    idx_d       = idx_q + 4'd1;
                    m_rw_d      = 1'b0;
                    m_data_wr_d = REG_BASE + {4'b0000, idx_q + 4'd1};
                    state_d     = S_PTR_REQ;
                end
            end
            S_FAIL: begin
                if (retry_q < RETRY_MAX) begin
                    retry_d     = retry_q + 1'b1;
                    m_rw_d      = 1'b0;
                    m_data_wr_d = REG_BASE + {4'b0000, idx_q};
                    state_d     = S_PTR_REQ;
                end else begin
                    err_nack_d    = !fail_tmo_q;
                    err_timeout_d = fail_tmo_q;
                    frame_ok_d    = 1'b0;
                    frame_done_d  = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            period_cnt_q  <= PERIOD_LAST;
            idx_q         <= '0;
            retry_q       <= '0;
            m_start_q     <= 1'b0;
            m_rw_q        <= 1'b0;
            m_data_wr_q   <= '0;
            out_valid_q   <= 1'b0;
            out_index_q   <= '0;
            out_data_q    <= '0;
            frame_done_q  <= 1'b0;
            frame_ok_q    <= 1'b0;
            err_nack_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            overrun_q     <= 1'b0;
            fail_tmo_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            period_cnt_q  <= period_cnt_d;
            idx_q         <= idx_d;
            retry_q       <= retry_d;
            m_start_q     <= m_start_d;
            m_rw_q        <= m_rw_d;
            m_data_wr_q   <= m_data_wr_d;
            out_valid_q   <= out_valid_d;
            out_index_q   <= out_index_d;
            out_data_q    <= out_data_d;
            frame_done_q  <= frame_done_d;
            frame_ok_q    <= frame_ok_d;
            err_nack_q    <= err_nack_d;
            err_timeout_q <= err_timeout_d;
            overrun_q     <= overrun_d;
            fail_tmo_q    <= fail_tmo_d;
        end
    end

    assign m_start     = m_start_q;
    assign m_addr      = SLAVE_ADDR;
    assign m_rw        = m_rw_q;
    assign m_data_wr   = m_data_wr_q;
    assign seq_busy    = (state_q != S_IDLE);
    assign out_valid   = out_valid_q;
    assign out_index   = out_index_q;
    assign out_data    = out_data_q;
    assign frame_done  = frame_done_q;
    assign frame_ok    = frame_ok_q;
    assign err_nack    = err_nack_q;
    assign err_timeout = err_timeout_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_i2c_poll_sequencer.sv
// Bench for i2c_poll_sequencer: randomized I2C master model, transaction-level reference model and scoreboard.
module tb_i2c_poll_sequencer;

    localparam logic [6:0] SLAVE  = 7'h48;
    localparam logic [7:0] BASE   = 8'hFE;
    localparam int         NREG   = 3;
    localparam int         PERIOD = 600;
    localparam int         MAXR   = 2;

    logic       clk = 1'b0;
    logic       rst_n, enable, trigger;
    logic       m_start, m_rw;
    logic [6:0] m_addr;
    logic [7:0] m_data_wr, m_data_rd;
    logic       m_busy, m_ack_error, m_done;
    logic       seq_busy, out_valid;
    logic [3:0] out_index;
    logic [7:0] out_data;
    logic       frame_done, frame_ok, err_nack, err_timeout, overrun;

    i2c_poll_sequencer #(
        .SLAVE_ADDR(SLAVE), .REG_BASE(BASE), .NUM_REGS(NREG),
        .POLL_PERIOD(PERIOD), .MAX_RETRY(MAXR), .TIMEOUT_CYCLES(200_000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .trigger(trigger),
        .m_start(m_start), .m_addr(m_addr), .m_rw(m_rw), .m_data_wr(m_data_wr),
        .m_data_rd(m_data_rd), .m_busy(m_busy), .m_ack_error(m_ack_error), .m_done(m_done),
        .seq_busy(seq_busy), .out_valid(out_valid), .out_index(out_index), .out_data(out_data),
        .frame_done(frame_done), .frame_ok(frame_ok), .err_nack(err_nack),
        .err_timeout(err_timeout), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state: where the frame should be, per the polling rules.
    bit          md_active = 0;
    int          md_idx, md_retry;
    bit          md_phase;
    logic [11:0] exp_res[$];
    bit          exp_frame[$];
    int          start_cyc[$];

    int nack_mode = 0;
    bit slow = 0, stray_req = 0, frame_active = 0, in_read = 0;
    int ptr_attempts = 0, n_frames_done = 0, n_overrun = 0, n_errnack = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input string detail);
        total++;
        bad++;
        $display("FAIL %s: %s", name, detail);
    endtask

    task automatic model_start(input logic rw, input logic [7:0] ptr, input int acc);
        logic [7:0] exp_ptr;
        if (!md_active) begin
            md_active = 1;
            md_idx    = 0;
            md_retry  = 0;
            md_phase  = 0;
            start_cyc.push_back(acc);
        end
        exp_ptr = BASE + 8'(md_idx);
        chk("txn_rw", rw, md_phase);
        chk("txn_ptr", ptr, exp_ptr);
    endtask

    task automatic model_done(input bit nack, input logic [7:0] data);
        if (!nack) begin
            if (!md_phase) begin
                md_phase = 1;
            end else begin
                exp_res.push_back({4'(md_idx), data});
                md_idx++;
                md_retry = 0;
                md_phase = 0;
                if (md_idx == NREG) begin
                    exp_frame.push_back(1'b1);
                    md_active = 0;
                end
            end
        end else if (md_retry < MAXR) begin
            md_retry++;
            md_phase = 0;
        end else begin
            exp_frame.push_back(1'b0);
            md_active = 0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // I2C byte master model.
    int         acc, lat, dur;
    bit         abort, nack;
    logic       t_rw;
    logic [7:0] t_ptr, t_dat;
    initial begin
        m_busy = 0; m_done = 0; m_ack_error = 0; m_data_rd = 0;
        forever begin
            @(negedge clk);
            if (stray_req && !m_busy) begin
                m_done = 1; m_ack_error = 1; m_data_rd = 8'hEE;
                @(negedge clk);
                m_done = 0; m_ack_error = 0;
                stray_req = 0;
            end else if (rst_n && m_start && !m_busy) begin
                acc   = cyc;
                t_rw  = m_rw;
                t_ptr = m_data_wr;
                chk("m_addr", m_addr, SLAVE);
                lat   = $urandom_range(0, 2);
                abort = 0;
                for (int i = 0; i < lat; i++) begin
                    @(negedge clk);
                    if (!rst_n) begin abort = 1; break; end
                end
                if (!abort) begin
                    chk("m_start_held", m_start, 1);
                    m_busy = 1;
                    model_start(t_rw, t_ptr, acc);
                    if (t_rw == 1'b0) ptr_attempts++;
                    else in_read = 1;
                    dur = slow ? 130 : $urandom_range(1, 6);
                    for (int i = 0; i < dur; i++) begin
                        @(negedge clk);
                        if (!rst_n) begin abort = 1; break; end
                        if (i == 0) chk("m_start_drop", m_start, 0);
                    end
                    in_read = 0;
                    if (abort) begin
                        m_busy = 0;
                    end else begin
                        case (nack_mode)
                            1:       nack = ($urandom_range(0, 3) == 0);
                            2:       nack = 1;
                            3:       nack = (md_idx == 0 && md_retry == 0 && md_phase == 0);
                            default: nack = 0;
                        endcase
                        t_dat = 8'($urandom);
                        m_busy = 0; m_done = 1; m_ack_error = nack; m_data_rd = t_dat;
                        model_done(nack, t_dat);
                        @(negedge clk);
                        m_done = 0; m_ack_error = 0;
                    end
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT strobes a result or ends a frame.
    logic [11:0] e_res;
    bit          e_ok;
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (out_valid) begin
                if (exp_res.size() == 0) begin
                    flag("out_valid_unexpected", $sformatf("got index=%0d data=%0h, expected no result", out_index, out_data));
                end else begin
                    e_res = exp_res.pop_front();
                    chk("out_index", out_index, e_res[11:8]);
                    chk("out_data", out_data, e_res[7:0]);
                end
            end
            if (err_nack) n_errnack++;
            if (overrun) n_overrun++;
            if (err_timeout) flag("err_timeout", "got 1, expected 0");
            if (frame_done) begin
                n_frames_done++;
                frame_active = 0;
                if (exp_frame.size() == 0) begin
                    flag("frame_done_unexpected", "got frame_done, expected none");
                end else begin
                    e_ok = exp_frame.pop_front();
                    chk("frame_ok", frame_ok, e_ok);
                    chk("err_nack_at_end", err_nack, !e_ok);
                end
            end else if (err_nack) begin
                flag("err_nack_alone", "got err_nack without frame_done, expected both together");
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (frame_active && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (frame_active) begin
            flag("frame_timeout", $sformatf("frame still active after %0d cycles, expected frame_done", budget));
            frame_active = 0;
        end
    endtask

    task automatic run_frame(input int mode, input bit mid_trig);
        nack_mode = mode;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        frame_active = 1;
        trigger = 1;
        @(negedge clk);
        trigger = 0;
        chk("trig_m_start_early", m_start, 0);
        @(negedge clk);
        chk("trig_m_start_latency", m_start, 1);
        if (mid_trig) begin
            repeat ($urandom_range(1, 4)) @(negedge clk);
            if (frame_active) begin
                trigger = 1;
                @(negedge clk);
                trigger = 0;
            end
        end
        wait_idle(3000);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_m_start"}, m_start, 0);
        chk({tag, "_m_addr"}, m_addr, SLAVE);
        chk({tag, "_m_rw_wr"}, {m_rw, m_data_wr}, 0);
        chk({tag, "_seq_busy"}, seq_busy, 0);
        chk({tag, "_out"}, {out_valid, out_index, out_data}, 0);
        chk({tag, "_flags"}, {frame_done, frame_ok, err_nack, err_timeout, overrun}, 0);
    endtask

    initial begin
        #600_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "global timeout");
    end

    int e0, f0, k;
    initial begin
        rst_n = 0; enable = 0; trigger = 0;
        repeat (3) @(negedge clk);
        chk_reset_outs("reset");
        rst_n = 1;
        repeat (2) @(negedge clk);

        run_frame(0, 0);
        e0 = n_errnack;
        run_frame(3, 0);
        chk("recovered_no_err_nack", n_errnack - e0, 0);
        chk("recovered_frame_ok", frame_ok, 1);

        ptr_attempts = 0;
        e0 = n_errnack;
        run_frame(2, 0);
        chk("exhaust_ptr_attempts", ptr_attempts, MAXR + 1);
        chk("exhaust_err_nack_pulses", n_errnack - e0, 1);

        for (int f = 0; f < 20; f++) begin
            if ($urandom_range(0, 2) == 0) begin
                stray_req = 1;
                for (int w = 0; w < 10 && stray_req; w++) @(negedge clk);
            end
            run_frame(1, $urandom_range(0, 1));
        end
        chk("random_drained", exp_res.size() + exp_frame.size(), 0);
        chk("no_overrun_disabled", n_overrun, 0);

        slow = 1; nack_mode = 0;
        start_cyc.delete();
        f0 = n_frames_done;
        enable = 1;
        for (int w = 0; w < 5000 && (n_frames_done - f0) < 3; w++) @(negedge clk);
        enable = 0;
        chk("overrun_frames", n_frames_done - f0, 3);
        chk("overrun_pulses", n_overrun, 3);
        chk("overrun_starts", start_cyc.size(), 3);
        if (start_cyc.size() == 3) begin
            chk("overrun_gap1", start_cyc[1] - start_cyc[0], 2 * PERIOD);
            chk("overrun_gap2", start_cyc[2] - start_cyc[1], 2 * PERIOD);
        end
        repeat (4) @(negedge clk);

        frame_active = 1;
        trigger = 1;
        @(negedge clk);
        trigger = 0;
        for (int w = 0; w < 400 && !in_read; w++) @(negedge clk);
        chk("reset_test_in_read", in_read, 1);
        repeat (3) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        chk_reset_outs("midreset");
        md_active = 0;
        frame_active = 0;
        @(negedge clk);
        rst_n = 1; enable = 1; slow = 0;
        k = 0;
        for (int w = 1; w <= PERIOD + 5; w++) begin
            @(negedge clk);
            if (m_start) begin k = w; break; end
        end
        chk("tick_start_latency", k, PERIOD + 1);
        frame_active = 1;
        wait_idle(3000);
        enable = 0;
        repeat (5) @(negedge clk);
        chk("frame_ok_held", frame_ok, 1);
        chk("final_drained", exp_res.size() + exp_frame.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
